// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue: small FIFO between the fetch and decode stages. It replaces
// the plain IF/ID register. Decode stalls are absorbed here, so fetch does not
// have to re-fetch. A taken jump flushes every wrong-path entry. When the queue
// is empty, decode is handed a NOP with out_valid low.
module ifid_fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013,
    localparam int               PTR_W    = $clog2(DEPTH),
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_inst_i,
    input  logic [DATA_W-1:0] in_pc_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_inst_o,
    output logic [DATA_W-1:0] out_pc_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [DATA_W-1:0] pc_mem_q   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    // Ready depends on occupancy alone. A full queue refuses a push even in a
    // cycle where decode pops, so there is no ready path through out_ready.
    assign in_ready_o  = (cnt_q < CNT_W'(DEPTH));
    assign out_valid_o = (cnt_q != '0);
    assign count_o     = cnt_q;
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    // The head is muxed from registered state. The valid gate keeps unwritten or
    // stale storage off the outputs.
    assign out_inst_o = out_valid_o ? inst_mem_q[rd_ptr_q] : NOP_INST;
    assign out_pc_o   = out_valid_o ? pc_mem_q[rd_ptr_q]   : '0;

    // Next-state logic for pointers and count. Flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register. Reset is asynchronous and takes effect at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage. It has no reset because its contents are only observed
    // through the valid-gated head mux.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= in_inst_i;
            pc_mem_q[wr_ptr_q]   <= in_pc_i;
        end
    end

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed bench for ifid_fetch_queue (DEPTH=2). Inputs are driven and outputs
// are sampled 1ns after the rising edge.
module tb_ifid_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    ifid_fetch_queue #(.DATA_W(32), .DEPTH(2), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_inst_i(in_inst), .in_pc_i(in_pc),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_inst_o(out_inst), .out_pc_o(out_pc),
        .count_o(count)
    );

    always #5 clk = ~clk;

    // Instruction word paired with each pc: a recognisable tag in the upper half.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hBEEF, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst_of(pc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; out_ready = 0; flush = 0; in_pc = 0; in_inst = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL reset_inst got %h want %h", out_inst, NOP); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", out_pc); end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        // Fill the queue, then assert reset in the middle of a cycle.
        offer(32'hA0); tick();
        offer(32'hA4); tick();
        in_valid = 0;
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL pre_rst_count got %0d want 2", count); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL async_rst_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got %b want 1", in_ready); end
        n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL async_rst_inst got %h want %h", out_inst, NOP); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL async_rst_pc got %h want 0", out_pc); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3] = '{32'h00, 32'h04, 32'h08};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            offer(pcs[i]);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            n_cmp++; if (out_pc !== pcs[i]) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, pcs[i]); end
            n_cmp++; if (out_inst !== inst_of(pcs[i])) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", i, out_inst, inst_of(pcs[i])); end
            n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
        end
        in_valid = 0;
        tick();
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL stream_drain got %0d want 0", count); end
    endtask

    task automatic test_stall_fill();
        out_ready = 0;
        offer(32'h10); tick();
        n_cmp++; if (out_pc !== 32'h10) begin n_err++; $display("FAIL fill_head got %h want 10", out_pc); end
        offer(32'h14); tick();
        offer(32'h18);
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL fill_count got %0d want 2", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b want 0", in_ready); end
        tick();
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL fill_refused got %0d want 2", count); end
        n_cmp++; if (out_pc !== 32'h10) begin n_err++; $display("FAIL fill_hold got %h want 10", out_pc); end
        out_ready = 1;   // 0x18 is still being offered
        tick();
        n_cmp++; if (out_pc !== 32'h14) begin n_err++; $display("FAIL release_1 got %h want 14", out_pc); end
        n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL release_cnt got %0d want 1", count); end
        tick();
        n_cmp++; if (out_pc !== 32'h18) begin n_err++; $display("FAIL release_2 got %h want 18", out_pc); end
        in_valid = 0;
        tick();
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL stall_drain got %0d want 0", count); end
    endtask

    task automatic test_full_pop();
        out_ready = 0;
        offer(32'h20); tick();
        offer(32'h24); tick();
        out_ready = 1;
        offer(32'h28);
        tick();
        n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL fullpop_count got %0d want 1", count); end
        n_cmp++; if (out_pc !== 32'h24) begin n_err++; $display("FAIL fullpop_head got %h want 24", out_pc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fullpop_ready got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_pc !== 32'h28) begin n_err++; $display("FAIL fullpop_next got %h want 28", out_pc); end
        in_valid = 0;
        tick();
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL fullpop_drain got %0d want 0", count); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        offer(32'h30); tick();
        offer(32'h34); tick();
        offer(32'h40);
        flush = 1; out_ready = 1;
        tick();
        flush = 0; in_valid = 0; out_ready = 0;
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL flush_inst got %h want %h", out_inst, NOP); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
        offer(32'h80);
        tick();
        in_valid = 0;
        n_cmp++; if (out_pc !== 32'h80) begin n_err++; $display("FAIL flush_next got %h want 80", out_pc); end
        n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL flush_next_cnt got %0d want 1", count); end
        out_ready = 1;
        tick();
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL flush_drain got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        out_ready = 1;
        offer(32'h100);
        tick();
        // Seven push/pop pairs. The head always lags the newest push by one, and
        // both pointers wrap several times.
        for (int k = 1; k <= 7; k++) begin
            offer(32'h100 + 32'(4 * k));
            exp_pc = 32'h100 + 32'(4 * (k - 1));
            n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc[%0d] got %h want %h", k, out_pc, exp_pc); end
            n_cmp++; if (out_inst !== inst_of(exp_pc)) begin n_err++; $display("FAIL wrap_inst[%0d] got %h want %h", k, out_inst, inst_of(exp_pc)); end
            tick();
            n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 1", k, count); end
        end
        in_valid = 0;
        n_cmp++; if (out_pc !== 32'h11C) begin n_err++; $display("FAIL wrap_last got %h want 11c", out_pc); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_full_pop();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
